// File: rtl/arith_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arith_pkg: shared types and sizing helpers for the serial arithmetic |
// | path.                                                    Rev 1.0     |
// +----------------------------------------------------------------------+
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } serial_add_state_t;

  // Number of digit steps needed to cover the whole operand.
  function automatic int cycle_count(input int width, input int digit);
    return width / digit;
  endfunction

  // Step counter width; a single-step adder still needs a 1-bit counter.
  function automatic int counter_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder_fulladd.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | halfadd / fulladd: one-bit adder cells used by the serial adder.     |
// |                                                          Rev 1.0     |
// +----------------------------------------------------------------------+
module halfadd (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

module fulladd (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_s0;
  logic w_c0;
  logic w_c1;

  halfadd u_ha0 (
    .a (a),
    .b (b),
    .s (w_s0),
    .c (w_c0)
  );

  halfadd u_ha1 (
    .a (w_s0),
    .b (ci),
    .s (s),
    .c (w_c1)
  );

  assign co = w_c0 | w_c1;

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_adder: multi-cycle add/subtract, DIGIT bits per clock, LSB    |
// | first, valid/ready on both sides, returns s/c/v/z.       Rev 1.0     |
// +----------------------------------------------------------------------+
module serial_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             v,
  output logic             z
);

  localparam int N     = cycle_count(WIDTH, DIGIT);
  localparam int CNT_W = counter_width(N);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N - 1);

  serial_add_state_t r_state;
  serial_add_state_t w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_part;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] r_s;
  logic             r_c;
  logic             r_v;
  logic             r_z;

  logic [DIGIT:0]   w_carry;
  logic [DIGIT-1:0] w_digit;
  logic [WIDTH-1:0] w_part_next;
  logic             w_accept;
  logic             w_run;
  logic             w_last;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign s         = r_s;
  assign c         = r_c;
  assign v         = r_v;
  assign z         = r_z;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_run    = (r_state == RUN);
  assign w_last   = w_run && (r_cnt == C_LAST);

  // Ripple of DIGIT full-adder cells fed from the low end of the operand shifters.
  assign w_carry[0] = r_carry;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    fulladd u_fa (
      .a  (r_a[i]),
      .b  (r_b[i]),
      .ci (w_carry[i]),
      .s  (w_digit[i]),
      .co (w_carry[i+1])
    );
  end

  // New digit enters from the top so the last step leaves the result aligned.
  assign w_part_next = (r_part >> DIGIT) | (WIDTH'(w_digit) << (WIDTH - DIGIT));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_next = RUN;
      RUN:     if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_part  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_c     <= 1'b0;
      r_v     <= 1'b0;
      r_z     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_a     <= in1;
        r_b     <= sub ? ~in2 : in2;
        r_carry <= sub ? 1'b1 : cin;
        r_cnt   <= '0;
      end else if (w_run) begin
        r_a     <= r_a >> DIGIT;
        r_b     <= r_b >> DIGIT;
        r_carry <= w_carry[DIGIT];
        r_part  <= w_part_next;
        r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
      end
      // Final step holds bit WIDTH-1 in the top cell, so its carry-in/out give v.
      if (w_last) begin
        r_s <= w_part_next;
        r_c <= w_carry[DIGIT];
        r_v <= w_carry[DIGIT-1] ^ w_carry[DIGIT];
        r_z <= (w_part_next == '0);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_serial_adder: randomized and directed bench for serial_adder,     |
// | WIDTH=8/DIGIT=1 and WIDTH=16/DIGIT=4 instances.          Rev 1.0     |
// +----------------------------------------------------------------------+
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic       iv8 = 0, ir8, ov8, or8 = 0, sub8 = 0, cin8 = 0, c8, v8, z8;
  logic [7:0] a8 = 0, b8 = 0, s8;
  logic        iv16 = 0, ir16, ov16, or16 = 0, sub16 = 0, cin16 = 0, c16, v16, z16;
  logic [15:0] a16 = 0, b16 = 0, s16;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in1(a8), .in2(b8),
    .sub(sub8), .cin(cin8), .out_valid(ov8), .out_ready(or8),
    .s(s8), .c(c8), .v(v8), .z(z8)
  );

  serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in1(a16), .in2(b16),
    .sub(sub16), .cin(cin16), .out_valid(ov16), .out_ready(or16),
    .s(s16), .c(c16), .v(v16), .z(z16)
  );

  // Reference: unsigned value for s/c, signed integer range for v.
  function automatic void model(input int w, input longint a, input longint b,
                                input bit sb, input bit ci, output logic [63:0] es,
                                output logic ec, output logic ev, output logic ez);
    longint m, sa, sbv, u, r;
    m   = longint'(1) << w;
    sa  = (a >= m / 2) ? a - m : a;
    sbv = (b >= m / 2) ? b - m : b;
    if (sb) begin
      u  = a - b;
      ec = (a >= b);
      r  = sa - sbv;
    end else begin
      u  = a + b + longint'(ci);
      ec = (u >= m);
      r  = sa + sbv + longint'(ci);
    end
    es = 64'(((u % m) + m) % m);
    ev = (r >= m / 2) || (r < -(m / 2));
    ez = (es == 0);
  endfunction

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sb, input logic ci,
                      output logic [10:0] res, output int lat);
    @(negedge clk);
    a8 = a; b8 = b; sub8 = sb; cin8 = ci; iv8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = {s8, c8, v8, z8};
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic sb, input logic ci,
                       output logic [18:0] res, output int lat);
    @(negedge clk);
    a16 = a; b16 = b; sub16 = sb; cin16 = ci; iv16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv16 = 1'b0;
    lat = 0;
    while (!ov16 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = {s16, c16, v16, z16};
    or16 = 1'b1;
    @(negedge clk);
    or16 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({ir8, ov8, s8, c8, v8, z8} !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
      n_err++;
      $display("FAIL reset8: got %b expected %b", {ir8, ov8, s8, c8, v8, z8}, {1'b1, 1'b0, 8'h00, 3'b000});
    end
    n_cmp++;
    if ({ir16, ov16, s16, c16, v16, z16} !== {1'b1, 1'b0, 16'h0000, 3'b000}) begin
      n_err++;
      $display("FAIL reset16: got %b expected %b", {ir16, ov16, s16, c16, v16, z16}, {1'b1, 1'b0, 16'h0000, 3'b000});
    end
    rst = 1'b0;
  endtask

  // Directed 8-bit vectors from both modes, checked against the model and fixed values.
  task automatic test_directed8();
    logic [7:0]  ta [6] = '{8'h0F, 8'hFF, 8'h7F, 8'h05, 8'h80, 8'h00};
    logic [7:0]  tb [6] = '{8'h01, 8'h01, 8'h00, 8'h07, 8'h01, 8'h00};
    logic        ts [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        tc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [10:0] tx [6] = '{{8'h10, 3'b000}, {8'h00, 3'b101}, {8'h80, 3'b010},
                            {8'hFE, 3'b000}, {8'h7F, 3'b110}, {8'h00, 3'b101}};
    logic [10:0] got;
    logic [63:0] es;
    logic        ec, ev, ez;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      run8(ta[i], tb[i], ts[i], tc[i], got, lat);
      model(8, longint'(ta[i]), longint'(tb[i]), ts[i], tc[i], es, ec, ev, ez);
      n_cmp++;
      if (got !== tx[i] || got !== {es[7:0], ec, ev, ez}) begin
        n_err++;
        $display("FAIL directed8[%0d]: got s,c,v,z=%b expected %b", i, got, tx[i]);
      end
      n_cmp++;
      if (lat !== 8) begin
        n_err++;
        $display("FAIL latency8[%0d]: got %0d expected 8", i, lat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [10:0] held;
    logic [10:0] got;
    logic [63:0] es;
    logic        ec, ev, ez;
    int          lat;
    @(negedge clk);
    a8 = 8'h3C; b8 = 8'h5A; sub8 = 1'b1; cin8 = 1'b0; iv8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    model(8, 64'h3C, 64'h5A, 1'b1, 1'b0, es, ec, ev, ez);
    held = {es[7:0], ec, ev, ez};
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if ({ov8, ir8, s8, c8, v8, z8} !== {1'b1, 1'b0, held}) begin
        n_err++;
        $display("FAIL backpressure[%0d]: got %b expected %b", k, {ov8, ir8, s8, c8, v8, z8}, {1'b1, 1'b0, held});
      end
      iv8 = k[0];
      a8 = 8'(($urandom));
      @(negedge clk);
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    n_cmp++;
    if ({ov8, ir8} !== 2'b01) begin
      n_err++;
      $display("FAIL after_handshake: got ov,ir=%b expected 01", {ov8, ir8});
    end
    run8(8'h21, 8'h13, 1'b0, 1'b0, got, lat);
    n_cmp++;
    if (got !== {8'h34, 3'b000}) begin
      n_err++;
      $display("FAIL post_backpressure_op: got %b expected %b", got, {8'h34, 3'b000});
    end
  endtask

  task automatic test_reset_mid_run();
    logic [10:0] got;
    int          lat;
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h22; sub8 = 1'b0; cin8 = 1'b0; iv8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({ov8, ir8, s8} !== {1'b0, 1'b1, 8'h00}) begin
      n_err++;
      $display("FAIL reset_mid_run: got ov,ir,s=%b expected %b", {ov8, ir8, s8}, {1'b0, 1'b1, 8'h00});
    end
    run8(8'h01, 8'h01, 1'b0, 1'b0, got, lat);
    n_cmp++;
    if (got[10:3] !== 8'h02 || lat !== 8) begin
      n_err++;
      $display("FAIL after_reset_op: got s=%h lat=%0d expected s=02 lat=8", got[10:3], lat);
    end
  endtask

  task automatic test_directed16();
    logic [18:0] got;
    int          lat;
    run16(16'h1234, 16'hEDCC, 1'b0, 1'b0, got, lat);
    n_cmp++;
    if (got !== {16'h0000, 3'b101}) begin
      n_err++;
      $display("FAIL directed16: got %b expected %b", got, {16'h0000, 3'b101});
    end
    n_cmp++;
    if (lat !== 4) begin
      n_err++;
      $display("FAIL latency16: got %0d expected 4", lat);
    end
  endtask

  task automatic test_random();
    logic [18:0] got16;
    logic [10:0] got8;
    logic [63:0] es;
    logic        ec, ev, ez, rs, rc;
    logic [15:0] ra, rb;
    int          lat;
    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      rb = (i % 10 == 0) ? ra : 16'($urandom);
      rs = 1'($urandom);
      rc = 1'($urandom);
      run16(ra, rb, rs, rc, got16, lat);
      model(16, longint'(ra), longint'(rb), rs, rc, es, ec, ev, ez);
      n_cmp++;
      if (got16 !== {es[15:0], ec, ev, ez} || lat !== 4) begin
        n_err++;
        $display("FAIL random16[%0d] %h %s %h cin=%b: got %b lat=%0d expected %b", i, ra, rs ? "-" : "+",
                 rb, rc, got16, lat, {es[15:0], ec, ev, ez});
      end
    end
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom_range(0, 255));
      rb = 16'($urandom_range(0, 255));
      rs = 1'($urandom);
      rc = 1'($urandom);
      run8(ra[7:0], rb[7:0], rs, rc, got8, lat);
      model(8, longint'(ra[7:0]), longint'(rb[7:0]), rs, rc, es, ec, ev, ez);
      n_cmp++;
      if (got8 !== {es[7:0], ec, ev, ez} || lat !== 8) begin
        n_err++;
        $display("FAIL random8[%0d] %h %s %h cin=%b: got %b lat=%0d expected %b", i, ra[7:0], rs ? "-" : "+",
                 rb[7:0], rc, got8, lat, {es[7:0], ec, ev, ez});
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed8();
    test_backpressure();
    test_reset_mid_run();
    test_directed16();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
